// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder.
// Contents:
//   state_t    - decoder FSM states (INIT, RUN)
//   step_t     - per-cycle decode result (HOLD, INC, DEC, ERR)
//   INC_*      - the four {ab_q, ab_now} codes that count up (A leads B)
//   quad_step  - classifies one {previous, current} AB pair
package quad_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        HOLD,
        INC,
        DEC,
        ERR
    } step_t;

    // Transition codes are {ab_q, ab_now} with ab = {A, B}.
    localparam logic [3:0] INC_00_10 = 4'b0010;
    localparam logic [3:0] INC_10_11 = 4'b1011;
    localparam logic [3:0] INC_11_01 = 4'b1101;
    localparam logic [3:0] INC_01_00 = 4'b0100;

    function automatic step_t quad_step(input logic [1:0] ab_q, input logic [1:0] ab_now);
        logic [3:0] code;
        code = {ab_q, ab_now};
        if (ab_q == ab_now) begin
            return HOLD;
        end else if ((ab_q ^ ab_now) == 2'b11) begin
            // Both channels moved in one sample: direction is unknowable.
            return ERR;
        end else if (code == INC_00_10 || code == INC_10_11 ||
                     code == INC_11_01 || code == INC_01_00) begin
            return INC;
        end else begin
            // Every remaining single-bit change is the reverse of an increment.
            return DEC;
        end
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Signal bundle between the debounced encoder inputs / host controls and
// the quadrature decoder.
//   master : drives QUAD_A, QUAD_B, QUAD_Z, index_enable, error_clear;
//            observes position, index_position, index_latched, quad_error
//   slave  : the decoder side (mirror of master)
interface quad_decoder_if #(
    parameter int WIDTH = 32
);
    logic             QUAD_A;
    logic             QUAD_B;
    logic             QUAD_Z;
    logic             index_enable;
    logic             error_clear;
    logic [WIDTH-1:0] position;
    logic [WIDTH-1:0] index_position;
    logic             index_latched;
    logic             quad_error;

    modport master (
        output QUAD_A, QUAD_B, QUAD_Z, index_enable, error_clear,
        input  position, index_position, index_latched, quad_error
    );

    modport slave (
        input  QUAD_A, QUAD_B, QUAD_Z, index_enable, error_clear,
        output position, index_position, index_latched, quad_error
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: turns debounced, clk-synchronous A/B levels into a
// wrapping two's-complement position (4 counts per electrical cycle) and a
// sticky illegal-transition flag.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous assert, active-low reset
//   bus    - quad_decoder_if.slave (A/B/Z inputs, index_enable, error_clear,
//            position, index_position, index_latched, quad_error)
// Build option:
//   QUAD_INDEX_EN - when defined, a Z rising edge while armed captures the
//   position into index_position, zeroes position and sets index_latched.
//   When undefined, QUAD_Z/index_enable are ignored and the index outputs
//   stay 0.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst_n,
    quad_decoder_if.slave bus
);

    state_t           state_reg, state_next;
    logic [1:0]       ab_reg, ab_next;
    logic             z_reg, z_next;
    logic [WIDTH-1:0] pos_reg, pos_next;
    logic [WIDTH-1:0] idx_pos_reg, idx_pos_next;
    logic             lat_reg, lat_next;
    logic             err_reg, err_next;
    logic [1:0]       ab_now;
    step_t            step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= INIT;
            ab_reg      <= 2'b00;
            z_reg       <= 1'b0;
            pos_reg     <= '0;
            idx_pos_reg <= '0;
            lat_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ab_reg      <= ab_next;
            z_reg       <= z_next;
            pos_reg     <= pos_next;
            idx_pos_reg <= idx_pos_next;
            lat_reg     <= lat_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        ab_now       = {bus.QUAD_A, bus.QUAD_B};
        state_next   = state_reg;
        ab_next      = ab_reg;
        z_next       = z_reg;
        pos_next     = pos_reg;
        idx_pos_next = idx_pos_reg;
        lat_next     = lat_reg;
        err_next     = err_reg;
        step         = HOLD;

        // Clear first so that a same-cycle illegal transition below wins.
        if (bus.error_clear) begin
            err_next = 1'b0;
        end

        case (state_reg)
            INIT: begin
                // Take the live levels as the reference without counting, so
                // nonzero inputs at reset release never produce a count.
                ab_next    = ab_now;
                z_next     = bus.QUAD_Z;
                state_next = RUN;
            end
            RUN: begin
                ab_next = ab_now;
                z_next  = bus.QUAD_Z;
                step    = quad_step(ab_reg, ab_now);
                case (step)
                    INC:     pos_next = pos_reg + WIDTH'(1);
                    DEC:     pos_next = pos_reg - WIDTH'(1);
                    ERR:     err_next = 1'b1;
                    default: ;
                endcase
`ifdef QUAD_INDEX_EN
                // Capture includes this cycle's delta; the new origin discards it.
                if (!z_reg && bus.QUAD_Z && bus.index_enable && !lat_reg) begin
                    idx_pos_next = pos_next;
                    pos_next     = '0;
                    lat_next     = 1'b1;
                end
`endif
            end
            default: state_next = INIT;
        endcase

`ifdef QUAD_INDEX_EN
        // Dropping the arm request releases the latch and permits a re-arm.
        if (!bus.index_enable) begin
            lat_next = 1'b0;
        end
`endif
    end

`ifndef QUAD_INDEX_EN
    logic unused_index;
    assign unused_index = &{1'b0, z_reg, bus.index_enable};
`endif

    assign bus.position       = pos_reg;
    assign bus.index_position = idx_pos_reg;
    assign bus.index_latched  = lat_reg;
    assign bus.quad_error     = err_reg;

endmodule
